osbm: RTL and testbench
=======================

# osbm

Output-side buffer manager for one switch output port: the responder end of the input-side request/ack handshake. It arbitrates round-robin among up to four input-side managers requesting this output and returns a one-cycle acknowledge to the winner. It then forwards that input's flit stream into the output FIFO until the input stops reading, and only then releases the output for the next packet.

## Interface
- W, 8, flit width in bits; includes the 2-bit packet-type field.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  4  request from input port i for this output; held by the requester until it sees ack.
- ack  out  4  one-hot, one-cycle acknowledge to the granted input port; registered.
- re_i  in  4  read enable of each input port's FIFO; port i's flit is on din while re_i[i] is high.
- din  in  4*W  flattened flit data; port i occupies bits [i*W +: W]; show-ahead, valid in the same cycle as re_i[i].
- full  in  1  output FIFO full.
- we  out  1  output FIFO write enable; registered.
- dout  out  W  flit to output FIFO; registered.
- busy  out  1  high while the output is granted (state ACK or XFER).
- ovf  out  1  sticky overflow flag: a flit arrived while full was high.

## Operation
- State encoding: IDLE=2'b00, ACK=2'b01, XFER=2'b10. 2'b11 is illegal and goes to IDLE.
- Internal registers: sel[1:0] (granted port) and ptr[1:0] (round-robin start).
- IDLE:
  - If full=0 and any req bit is set, choose the first set bit scanning ptr, ptr+1, ... (mod 4).
  - Load sel with that port and go to ACK.
  - If full=1, no grant is made and the state stays IDLE.
- ACK:
  - ack[sel]=1 for exactly this cycle; all other ack bits are 0.
  - Go to XFER unconditionally.
- XFER:
  - Stay while re_i[sel]=1.
  - When re_i[sel]=0, go to IDLE and set ptr=sel+1 (mod 4, 3 wraps to 0).
- Capture (in ACK and XFER only):
  - Registered we <= re_i[sel] & ~full.
  - Registered dout <= din[sel] when re_i[sel]=1, otherwise held.
  - re_i of non-selected ports is ignored. In IDLE, we <= 0.
- Overflow: if re_i[sel]=1 and full=1 in ACK or XFER:
  - The flit is dropped (we=0).
  - ovf is set and stays set until rst.
- Requests from non-selected ports are held pending and are not acknowledged until the current packet completes.
- Reset values: state=IDLE, sel=0, ptr=0, ack=0, we=0, dout=0, busy=0, ovf=0. Reset mid-packet aborts immediately, with no further we or ack.

## Timing
- Grant latency: req sampled high at edge n gives ack high during cycle n..n+1 (one clock). The requester raises re_i combinationally in that same cycle.
- Data latency: one cycle. A flit present with re_i[sel] in cycle t appears on dout with we=1 in cycle t+1.
- A k-flit packet (re_i[sel] high for k consecutive cycles starting in the ACK cycle) gives k consecutive we pulses. The state returns to IDLE on the edge after re_i[sel] falls.
- The earliest next ack is 2 cycles after re_i[sel] falls: one edge to reach IDLE, one to reach ACK.
- If re_i[sel] is already low in the ACK cycle (zero-length packet), the FSM still enters XFER and exits on the next edge with no we.
- busy is high exactly in the ACK and XFER cycles.

## Test plan
- Single requester: req=4'b0100 held, 3-flit packet A1..A3 → ack=4'b0100 for one cycle; we high 3 cycles with dout=A1,A2,A3; ptr=3; busy low afterwards.
- Round-robin: req=4'b1111 held continuously, each packet 1 flit → grants issued in order 0,1,2,3,0.
- Pointer wrap: ptr=3, req=4'b1001 → port 3 granted first, then port 0; after port 3 completes, ptr=0.
- Full blocking: full=1 in IDLE with req=4'b0001 → no ack. full drops → ack[0] on the next cycle.
- Overflow: full rises during the 2nd of 4 flits → that flit is not written (we=0), ovf=1 from the next cycle and stays set; the other flits are written normally.
- Reset mid-XFER: assert rst during flit 2 → ack, we, busy, and ovf go to 0 immediately; after release, a pending req=4'b0010 is granted fresh with ptr starting at 0.

Source files
------------

// File: rtl/osbm_if.sv
// Request/ack and flit bundle between the input-side managers and one output-side buffer manager.
interface osbm_if #(
  parameter int unsigned W = 8
);
  logic [3:0]     req;
  logic [3:0]     ack;
  logic [3:0]     re_i;
  logic [4*W-1:0] din;
  logic           full;
  logic           we;
  logic [W-1:0]   dout;
  logic           busy;
  logic           ovf;

  modport master (output req, re_i, din, full, input ack, we, dout, busy, ovf);
  modport slave  (input req, re_i, din, full, output ack, we, dout, busy, ovf);
endinterface

// File: rtl/osbm.sv
// Output-side buffer manager: round-robin grant among four inputs, then forwards the
// granted input's flit stream into the output FIFO until that input stops reading.
module osbm #(
  parameter int unsigned W = 8
) (
  input  logic   clk,
  input  logic   rst,
  osbm_if.slave  bus_io
);

  localparam int unsigned NPORT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACK  = 2'b01,
    XFER = 2'b10
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   sel_q, sel_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [3:0]   ack_q, ack_d;
  logic         we_q, we_d;
  logic [W-1:0] dout_q, dout_d;
  logic         busy_q, busy_d;
  logic         ovf_q, ovf_d;

  logic         grant_vld;
  logic [1:0]   grant_idx;
  logic         re_sel;
  logic [W-1:0] din_sel;
  logic         capture;

  assign re_sel  = bus_io.re_i[sel_q];
  assign din_sel = bus_io.din[32'(sel_q) * W +: W];
  assign capture = (state_q == ACK) || (state_q == XFER);

  // First requesting port found when scanning upward from the round-robin pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (!grant_vld && bus_io.req[ptr_q + 2'(i)]) begin
        grant_vld = 1'b1;
        grant_idx = ptr_q + 2'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    ack_d   = 4'b0000;
    we_d    = 1'b0;
    dout_d  = dout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (!bus_io.full && grant_vld) begin
          sel_d   = grant_idx;
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = XFER;
      end
      XFER: begin
        if (!re_sel) begin
          state_d = IDLE;
          ptr_d   = sel_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flits arriving while the FIFO is full are dropped and flagged.
    if (capture && re_sel) begin
      dout_d = din_sel;
      we_d   = ~bus_io.full;
      if (bus_io.full) begin
        ovf_d = 1'b1;
      end
    end

    if (state_d == ACK) begin
      ack_d[sel_d] = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      ack_q   <= 4'b0000;
      we_q    <= 1'b0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus_io.ack  = ack_q;
  assign bus_io.we   = we_q;
  assign bus_io.dout = dout_q;
  assign bus_io.busy = busy_q;
  assign bus_io.ovf  = ovf_q;

endmodule

// File: tb/tb_osbm.sv
// Directed bench for osbm: a cycle-by-cycle vector table plus a hand-written
// asynchronous-reset-mid-packet sequence.
module tb_osbm;

  localparam int unsigned W = 8;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  re;
    logic [31:0] din;
    logic        full;
    logic [3:0]  ack;
    logic        we;
    logic [7:0]  dout;
    logic        busy;
    logic        ovf;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t vecs[$];

  osbm_if #(.W(W)) bus ();

  osbm #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] re,
                     input logic [31:0] d, input logic f, input logic [3:0] a,
                     input logic w, input logic [7:0] o, input logic b, input logic v);
    vec_t t;
    t.rst = r; t.req = rq; t.re = re; t.din = d; t.full = f;
    t.ack = a; t.we = w; t.dout = o; t.busy = b; t.ovf = v;
    vecs.push_back(t);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req  = 4'b0000;
    bus.re_i = 4'b0000;
    bus.din  = 32'h0;
    bus.full = 1'b0;

    //   rst  req      re       din           full ack      we dout   busy ovf
    // single requester on port 2, 3 flits
    add(1'b0, 4'b0100, 4'b0000, 32'h00000000, 1'b0, 4'b0100, 1'b0, 8'h00, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 4'b0100, 32'h33A12211, 1'b0, 4'b0000, 1'b1, 8'hA1, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 4'b0100, 32'h44A25566, 1'b0, 4'b0000, 1'b1, 8'hA2, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 4'b0100, 32'h77A38899, 1'b0, 4'b0000, 1'b1, 8'hA3, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 32'hDEADBEEF, 1'b0, 4'b0000, 1'b0, 8'hA3, 1'b0, 1'b0);
    // pointer now 3: port 3 before port 0, then wrap to 0
    add(1'b0, 4'b1001, 4'b0000, 32'h00000000, 1'b0, 4'b1000, 1'b0, 8'hA3, 1'b1, 1'b0);
    add(1'b0, 4'b0001, 4'b1000, 32'h31C0C1C2, 1'b0, 4'b0000, 1'b1, 8'h31, 1'b1, 1'b0);
    add(1'b0, 4'b0001, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h31, 1'b0, 1'b0);
    add(1'b0, 4'b0001, 4'b0000, 32'h00000000, 1'b0, 4'b0001, 1'b0, 8'h31, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 4'b0001, 32'hAABBCC01, 1'b0, 4'b0000, 1'b1, 8'h01, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h01, 1'b0, 1'b0);
    // reset, then round robin with all four requesting
    add(1'b1, 4'b0000, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 4'b1111, 4'b0000, 32'h00000000, 1'b0, 4'b0001, 1'b0, 8'h00, 1'b1, 1'b0);
    add(1'b0, 4'b1111, 4'b0001, 32'h13121110, 1'b0, 4'b0000, 1'b1, 8'h10, 1'b1, 1'b0);
    add(1'b0, 4'b1111, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h10, 1'b0, 1'b0);
    add(1'b0, 4'b1111, 4'b0000, 32'h00000000, 1'b0, 4'b0010, 1'b0, 8'h10, 1'b1, 1'b0);
    add(1'b0, 4'b1111, 4'b0011, 32'h23222120, 1'b0, 4'b0000, 1'b1, 8'h21, 1'b1, 1'b0);
    add(1'b0, 4'b1111, 4'b0001, 32'h99999999, 1'b0, 4'b0000, 1'b0, 8'h21, 1'b0, 1'b0);
    add(1'b0, 4'b1111, 4'b0000, 32'h00000000, 1'b0, 4'b0100, 1'b0, 8'h21, 1'b1, 1'b0);
    add(1'b0, 4'b1111, 4'b0100, 32'h33323130, 1'b0, 4'b0000, 1'b1, 8'h32, 1'b1, 1'b0);
    add(1'b0, 4'b1111, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h32, 1'b0, 1'b0);
    add(1'b0, 4'b1111, 4'b0000, 32'h00000000, 1'b0, 4'b1000, 1'b0, 8'h32, 1'b1, 1'b0);
    add(1'b0, 4'b1111, 4'b1000, 32'h43424140, 1'b0, 4'b0000, 1'b1, 8'h43, 1'b1, 1'b0);
    add(1'b0, 4'b1111, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h43, 1'b0, 1'b0);
    add(1'b0, 4'b1111, 4'b0000, 32'h00000000, 1'b0, 4'b0001, 1'b0, 8'h43, 1'b1, 1'b0);
    add(1'b0, 4'b1111, 4'b0001, 32'h53525150, 1'b0, 4'b0000, 1'b1, 8'h50, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h50, 1'b0, 1'b0);
    // full blocks the grant, release gives ack next cycle
    add(1'b0, 4'b0001, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h50, 1'b0, 1'b0);
    add(1'b0, 4'b0001, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h50, 1'b0, 1'b0);
    add(1'b0, 4'b0001, 4'b0000, 32'h00000000, 1'b0, 4'b0001, 1'b0, 8'h50, 1'b1, 1'b0);
    // 4-flit packet, full during flit 2
    add(1'b0, 4'b0000, 4'b0001, 32'h00000020, 1'b0, 4'b0000, 1'b1, 8'h20, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 4'b0001, 32'h00000021, 1'b1, 4'b0000, 1'b0, 8'h21, 1'b1, 1'b1);
    add(1'b0, 4'b0000, 4'b0001, 32'h00000022, 1'b0, 4'b0000, 1'b1, 8'h22, 1'b1, 1'b1);
    add(1'b0, 4'b0000, 4'b0001, 32'h00000023, 1'b0, 4'b0000, 1'b1, 8'h23, 1'b1, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h23, 1'b0, 1'b1);
    // zero-length packet on port 2; other ports' read enables ignored
    add(1'b0, 4'b0100, 4'b0000, 32'h00000000, 1'b0, 4'b0100, 1'b0, 8'h23, 1'b1, 1'b1);
    add(1'b0, 4'b0000, 4'b1011, 32'hFFFFFFFF, 1'b0, 4'b0000, 1'b0, 8'h23, 1'b1, 1'b1);
    add(1'b0, 4'b0000, 4'b1011, 32'hFFFFFFFF, 1'b0, 4'b0000, 1'b0, 8'h23, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset.ack",  32'(bus.ack),  32'h0);
    chk("reset.we",   32'(bus.we),   32'h0);
    chk("reset.dout", 32'(bus.dout), 32'h0);
    chk("reset.busy", 32'(bus.busy), 32'h0);
    chk("reset.ovf",  32'(bus.ovf),  32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      rst      = vecs[i].rst;
      bus.req  = vecs[i].req;
      bus.re_i = vecs[i].re;
      bus.din  = vecs[i].din;
      bus.full = vecs[i].full;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.ack", i),  32'(bus.ack),  32'(vecs[i].ack));
      chk($sformatf("v%0d.we", i),   32'(bus.we),   32'(vecs[i].we));
      chk($sformatf("v%0d.dout", i), 32'(bus.dout), 32'(vecs[i].dout));
      chk($sformatf("v%0d.busy", i), 32'(bus.busy), 32'(vecs[i].busy));
      chk($sformatf("v%0d.ovf", i),  32'(bus.ovf),  32'(vecs[i].ovf));
    end

    // Reset asserted mid-packet, then a pending request is granted from pointer 0.
    rst = 1'b0;
    bus.req = 4'b0001; bus.re_i = 4'b0000; bus.full = 1'b0;
    @(posedge clk); #1;
    chk("rs.ack", 32'(bus.ack), 32'h1);
    bus.req = 4'b0000; bus.re_i = 4'b0001; bus.din = 32'h00000061;
    @(posedge clk); #1;
    chk("rs.flit1.we",   32'(bus.we),   32'h1);
    chk("rs.flit1.dout", 32'(bus.dout), 32'h61);
    bus.din = 32'h00000062; bus.req = 4'b1010;
    #2 rst = 1'b1;
    #1;
    chk("rs.async.ack",  32'(bus.ack),  32'h0);
    chk("rs.async.we",   32'(bus.we),   32'h0);
    chk("rs.async.busy", 32'(bus.busy), 32'h0);
    chk("rs.async.ovf",  32'(bus.ovf),  32'h0);
    chk("rs.async.dout", 32'(bus.dout), 32'h0);
    @(posedge clk); #1;
    chk("rs.hold.we",   32'(bus.we),   32'h0);
    chk("rs.hold.ack",  32'(bus.ack),  32'h0);
    chk("rs.hold.busy", 32'(bus.busy), 32'h0);
    rst = 1'b0; bus.re_i = 4'b0000;
    @(posedge clk); #1;
    chk("rs.regrant.ack",  32'(bus.ack),  32'h2);
    chk("rs.regrant.busy", 32'(bus.busy), 32'h1);
    bus.req = 4'b1000; bus.re_i = 4'b0010; bus.din = 32'h00007100;
    @(posedge clk); #1;
    chk("rs.p1.we",   32'(bus.we),   32'h1);
    chk("rs.p1.dout", 32'(bus.dout), 32'h71);
    bus.re_i = 4'b0000;
    @(posedge clk); #1;
    chk("rs.p1.end.busy", 32'(bus.busy), 32'h0);
    chk("rs.p1.end.we",   32'(bus.we),   32'h0);
    @(posedge clk); #1;
    chk("rs.p3.ack", 32'(bus.ack), 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
